// File: rtl/vram_scanout_if.sv
// Scanout bundle: control inputs, the vram read port and the outgoing pixel stream.
// The scanout block is the master; the vram/display side is the slave.
interface vram_scanout_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic              en;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_dout;
  logic [DATA_W-1:0] pix_data;
  logic              pix_de;
  logic              pix_hsync;
  logic              pix_vsync;
  logic              frame_start;

  modport master (
    input  en, base_addr, vram_dout,
    output vram_addr, pix_data, pix_de, pix_hsync, pix_vsync, frame_start
  );

  modport slave (
    output en, base_addr, vram_dout,
    input  vram_addr, pix_data, pix_de, pix_hsync, pix_vsync, frame_start
  );
endinterface

// File: rtl/vram_scanout.sv
// Raster scanout: free-running H/V counters drive the vram read address, and the
// timing flags ride a delay line so they land on the same clock as the returned pixel.
module vram_scanout #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1,
  parameter int SYNC_POL = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  vram_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int STAGES  = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SP      = (SYNC_POL != 0);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } tflags_t;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              run;     // low for the first enabled edge so (0,0) starts after it
  logic [ADDR_W-1:0] line_q;  // start address of the current line; loaded with base at (0,0)
  tflags_t           cur;
  tflags_t [STAGES:1] vld_pipe;

  always_comb begin
    cur = '0;
    if (run) begin
      cur.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      cur.hs  = (h_cnt >= HS_BEG) && (h_cnt <= HS_LAST);
      cur.vs  = (v_cnt >= VS_BEG) && (v_cnt <= VS_LAST);
      cur.fs  = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!bus.en) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Incremental addressing: line start steps by H_ACTIVE, pointer steps by one.
  // The address holds through blanking; those reads are dropped by the act flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q        <= '0;
      bus.vram_addr <= '0;
    end else if (!bus.en || !run) begin
      line_q        <= '0;
      bus.vram_addr <= '0;
    end else if (cur.fs) begin
      line_q        <= bus.base_addr;
      bus.vram_addr <= bus.base_addr;
    end else if (cur.act) begin
      if (h_cnt == '0) begin
        line_q        <= line_q + ADDR_W'(H_ACTIVE);
        bus.vram_addr <= line_q + ADDR_W'(H_ACTIVE);
      end else begin
        bus.vram_addr <= bus.vram_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe        <= '0;
      bus.pix_data    <= {DATA_W{1'b0}};
      bus.pix_de      <= 1'b0;
      bus.pix_hsync   <= ~SP;
      bus.pix_vsync   <= ~SP;
      bus.frame_start <= 1'b0;
    end else if (!bus.en) begin
      vld_pipe        <= '0;
      bus.pix_data    <= {DATA_W{1'b0}};
      bus.pix_de      <= 1'b0;
      bus.pix_hsync   <= ~SP;
      bus.pix_vsync   <= ~SP;
      bus.frame_start <= 1'b0;
    end else begin
      vld_pipe[1] <= cur;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      // vram_dout for this pixel is valid exactly when its flags reach the pipe tail
      bus.pix_data    <= vld_pipe[STAGES].act ? bus.vram_dout : {DATA_W{1'b0}};
      bus.pix_de      <= vld_pipe[STAGES].act;
      bus.pix_hsync   <= vld_pipe[STAGES].hs ? SP : ~SP;
      bus.pix_vsync   <= vld_pipe[STAGES].vs ? SP : ~SP;
      bus.frame_start <= vld_pipe[STAGES].fs;
    end
  end
endmodule

// File: tb/tb_vram_scanout.sv
// Randomized bench for vram_scanout on a small 8x4 raster, checked every clock
// against a frame-position reference model.
module tb_vram_scanout;
  localparam int AW    = 24;
  localparam int DW    = 8;
  localparam int H_TOT = 14;
  localparam int V_TOT = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_scanout #(
    .ADDR_W(AW), .DATA_W(DW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .RD_LAT(1), .SYNC_POL(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] mem(input logic [23:0] a);
    logic [31:0] t;
    t = {8'd0, a} * 32'd3;
    return t[7:0];
  endfunction

  // one-clock registered-read vram
  always @(posedge clk) bus.vram_dout <= mem(bus.vram_addr);

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: n = clocks since the frame origin; (h,v) and the pixel address come
  // straight from raster arithmetic; outputs emerge three edges after the state.
  typedef struct packed {
    logic [7:0] data;
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } px_t;

  px_t         q0, q1, e;
  int          n;
  bit          running;
  logic [23:0] fbase, exp_addr;

  task automatic model_rst();
    q0 = '0; q1 = '0; e = '0;
    n = 0; running = 1'b0; fbase = '0; exp_addr = '0;
  endtask

  task automatic model_edge();
    px_t nx;
    int  h, v;
    nx = '0;
    if (running) begin
      h = n % H_TOT;
      v = (n / H_TOT) % V_TOT;
      if (h == 0 && v == 0) fbase = bus.base_addr;
      nx.de = (h < 8) && (v < 4);
      nx.hs = (h >= 10) && (h < 12);
      nx.vs = (v == 5);
      nx.fs = (h == 0) && (v == 0);
      if (nx.de) begin
        exp_addr = fbase + 24'(v * 8 + h);
        nx.data  = mem(exp_addr);
      end
    end else begin
      exp_addr = '0;
    end
    if (!bus.en) begin
      e = '0; q0 = '0; q1 = '0; exp_addr = '0; running = 1'b0; n = 0;
    end else begin
      e = q0; q0 = q1; q1 = nx;
      if (running) n++;
      else begin running = 1'b1; n = 0; end
    end
  endtask

  task automatic cmp_all();
    chk("de",    32'(bus.pix_de),      32'(e.de));
    chk("data",  32'(bus.pix_data),    32'(e.data));
    chk("hsync", 32'(bus.pix_hsync),   32'(!e.hs));
    chk("vsync", 32'(bus.pix_vsync),   32'(!e.vs));
    chk("fs",    32'(bus.frame_start), 32'(e.fs));
    chk("addr",  32'(bus.vram_addr),   32'(exp_addr));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_rst();
    else model_edge();
    #1 cmp_all();
  endtask

  task automatic pulse_rst();
    #2 rst_n = 1'b0;
    #1 model_rst();
    cmp_all();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_fs(output int k);
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 300) begin
      cyc();
      if (bus.frame_start) seen = 1'b1;
      else k++;
    end
    chk("fs_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int first, second, de_n, hs_n, vs_n, k;
    logic [7:0] wrap_seq [4];
    wrap_seq[0] = 8'hFA; wrap_seq[1] = 8'hFD; wrap_seq[2] = 8'h00; wrap_seq[3] = 8'h03;

    bus.en = 1'b0;
    bus.base_addr = '0;
    model_rst();
    repeat (2) cyc();
    #2 rst_n = 1'b1;

    // two clean frames from a cold start
    bus.en = 1'b1;
    first = -1; second = -1; de_n = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < 199; i++) begin
      cyc();
      if (bus.pix_de) de_n++;
      if (!bus.pix_hsync) hs_n++;
      if (!bus.pix_vsync) vs_n++;
      if (bus.frame_start) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("fs_latency", 32'(first), 32'd3);
    chk("fs_period",  32'(second - first), 32'd98);
    chk("de_count",   32'(de_n), 32'd64);
    chk("hs_count",   32'(hs_n), 32'd28);
    chk("vs_count",   32'(vs_n), 32'd28);

    // base change mid-frame takes effect on the following frame
    repeat (20) cyc();
    bus.base_addr = 24'h000100;
    wait_fs(k);
    chk("base100_px0", 32'(bus.pix_data), 32'h00);
    cyc();
    chk("base100_px1", 32'(bus.pix_data), 32'h03);

    // address wrap at the top of the space
    bus.base_addr = 24'hFFFFFE;
    wait_fs(k);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      chk("wrap_px", 32'(bus.pix_data), 32'(wrap_seq[i]));
    end

    // async reset mid-line, then restart
    repeat (20) cyc();
    pulse_rst();
    wait_fs(k);
    chk("rst_fs_latency", 32'(k), 32'd3);
    chk("rst_px0", 32'(bus.pix_data), 32'hFA);

    // enable dropped for 5 clocks mid-frame
    repeat (30) cyc();
    bus.en = 1'b0;
    repeat (5) cyc();
    bus.en = 1'b1;
    wait_fs(k);
    chk("en_fs_latency", 32'(k), 32'd3);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0)
        bus.base_addr = $urandom_range(0, 1) ? 24'($urandom) : 24'hFFFFF0 + 24'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) bus.en = 1'b0;
      else if (!bus.en && $urandom_range(0, 3) == 0) bus.en = 1'b1;
      if ($urandom_range(0, 499) == 0) pulse_rst();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
